// File: rtl/vga_pkg.sv
// Shared VGA definitions: copper list entry layout, config/register addresses, copper FSM states.
package vga_pkg;

   localparam int unsigned PTR_W        = 4;
   localparam int unsigned ENT_LINE_LSB = 16;
   localparam int unsigned ENT_LINE_W   = 10;
   localparam int unsigned ENT_ADDR_LSB = 8;
   localparam int unsigned ENT_ADDR_W   = 6;
   localparam int unsigned ENT_VAL_LSB  = 0;
   localparam int unsigned ENT_VAL_W    = 6;

   localparam logic [4:0] CFG_CTRL_ADDR = 5'h1F;
   localparam logic [5:0] REG_BG_COLOR  = 6'h30;
   localparam logic [5:0] REG_FG_COLOR  = 6'h31;

   typedef struct packed {
      logic [ENT_LINE_W-1:0] line;
      logic [ENT_ADDR_W-1:0] addr;
      logic [ENT_VAL_W-1:0]  value;
   } copper_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_ISSUE,
      ST_DONE
   } copper_state_e;

endpackage

// File: rtl/vga_copper_ram.sv
// Copper list storage: DEPTH x WIDTH register file, one write port, one registered read port, no reset.
module vga_copper_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 22,
   parameter int unsigned AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/vga_copper.sv
// Raster-synchronised copper list player and VGA register write-port arbiter.
// Define VGA_COPPER_IRQ_EN to build the sticky list-done interrupt and its clear bit.
module vga_copper
   import vga_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned LINE_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [4:0]        cfg_addr,
   input  logic [31:0]       cfg_wdata,
   input  logic [LINE_W-1:0] vga_y,
   input  logic              vga_new_scanline,
   input  logic              frame_start,
   input  logic              cpu_req_we,
   input  logic [5:0]        cpu_req_addr,
   input  logic [31:0]       cpu_req_data,
   output logic              cpu_ready,
   output logic              reg_we,
   output logic [5:0]        reg_addr,
   output logic [31:0]       reg_wdata,
   output logic              busy,
   output logic              irq
);

   copper_state_e     state, state_nxt;
   logic [PTR_W-1:0]  ptr;
   logic [4:0]        len;
   logic              enable;
   logic              armed;
   logic [LINE_W-1:0] lat_y;
   copper_entry_t     cur;

   logic              ctrl_we, ent_we;
   logic [4:0]        len_wr, len_eff;
   logic              enable_eff;
   logic              last, fire;
   logic [LINE_W-1:0] cur_line;
   logic              unused_wdata;

   assign ctrl_we  = cfg_we && (cfg_addr == CFG_CTRL_ADDR);
   assign ent_we   = cfg_we && (cfg_addr < 5'(DEPTH));
   assign len_wr   = (cfg_wdata[12:8] > 5'(DEPTH)) ? 5'(DEPTH) : cfg_wdata[12:8];

   // Same-cycle control writes take effect for this cycle's frame_start/gating decision
   assign enable_eff = ctrl_we ? cfg_wdata[0] : enable;
   assign len_eff    = ctrl_we ? len_wr : len;

   assign last     = (({1'b0, ptr} + 5'd1) == len_eff);
   assign cur_line = LINE_W'(cur.line);
   assign fire     = armed && (lat_y >= cur_line);

   assign unused_wdata = ^{cfg_wdata[31:26], cfg_wdata[15:14], cfg_wdata[7:6]};

   vga_copper_ram #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(copper_entry_t)),
      .AW    (PTR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ent_we),
      .waddr (cfg_addr[PTR_W-1:0]),
      .wdata ({cfg_wdata[ENT_LINE_LSB +: ENT_LINE_W],
               cfg_wdata[ENT_ADDR_LSB +: ENT_ADDR_W],
               cfg_wdata[ENT_VAL_LSB  +: ENT_VAL_W]}),
      .re    (state == ST_FETCH),
      .raddr (ptr),
      .rdata (cur)
   );

   always_comb begin
      state_nxt = state;
      if (!enable_eff) begin
         state_nxt = ST_IDLE;
      end else if (frame_start) begin
         state_nxt = (len_eff != 5'd0) ? ST_FETCH : ST_DONE;
      end else begin
         case (state)
            ST_FETCH: state_nxt = ST_WAIT;
            ST_WAIT:  if (fire) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = last ? ST_DONE : ST_FETCH;
            default:  state_nxt = state;
         endcase
      end
   end

   always_comb begin
      reg_we    = cpu_req_we;
      reg_addr  = cpu_req_addr;
      reg_wdata = cpu_req_data;
      cpu_ready = 1'b1;
      busy      = (state == ST_FETCH) || (state == ST_WAIT) || (state == ST_ISSUE);
      if (state == ST_ISSUE) begin
         reg_we    = 1'b1;
         reg_addr  = cur.addr;
         reg_wdata = {26'd0, cur.value};
         cpu_ready = !cpu_req_we;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         ptr    <= '0;
         len    <= '0;
         enable <= 1'b0;
         armed  <= 1'b0;
         lat_y  <= '0;
      end else begin
         state <= state_nxt;
         if (ctrl_we) begin
            enable <= cfg_wdata[0];
            len    <= len_wr;
         end
         if (enable_eff && frame_start) ptr <= '0;
         else if (state == ST_ISSUE)    ptr <= ptr + PTR_W'(1);
         if (vga_new_scanline) begin
            armed <= 1'b1;
            lat_y <= vga_y;
         end else if (enable_eff && frame_start) begin
            armed <= 1'b0;
         end
      end
   end

`ifdef VGA_COPPER_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             irq_q <= 1'b0;
      else if (state == ST_ISSUE && last)     irq_q <= 1'b1;
      else if (ctrl_we && cfg_wdata[16])      irq_q <= 1'b0;
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule
